mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch requester (IF) and the data load/store requester (D) of the 5-stage pipelined core.
- Serialises accesses with one outstanding transaction and gives D priority, with a starvation guard for IF.
- Suppresses responses to fetches killed by a redirect.
- Drives per-requester stall outputs to the pipeline hazard logic.

Parameters:
- STARVE_MAX, 4: consecutive arbitration losses by a pending IF request before IF is forced to win. Legal range is 1..15.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  IF read request; held high until if_rvalid_o
- if_addr_i  in  32  IF word address; stable while if_req_i is high, except after if_kill_i
- if_kill_i  in  1  fetch redirect; discards the in-flight IF transaction
- if_rvalid_o  out  1  IF response valid, one-cycle pulse
- if_rdata_o  out  32  IF read data
- if_stall_o  out  1  IF stage must hold
- d_req_i  in  1  D request; held high until d_rvalid_o
- d_we_i  in  1  D write enable
- d_be_i  in  4  D byte enables
- d_addr_i  in  32  D address
- d_wdata_i  in  32  D write data
- d_rvalid_o  out  1  D response valid, one-cycle pulse; also asserted for writes
- d_rdata_o  out  32  D read data
- d_stall_o  out  1  MEM stage must hold
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepted the request this cycle
- mem_rvalid_i  in  1  memory response; every accepted request, read or write, gets exactly one
- mem_rdata_i  in  32  memory read data

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low; all state is cleared asynchronously on rst_ni low.
- Reset values:
  - state = IDLE, owner = D, starve counter = 0, kill flag = 0, request registers = 0.
  - All outputs are 0.
  - Reset mid-transaction abandons the transaction. The memory shares the same reset.
- States:
  - IDLE: no transaction. On any request, arbitrate, register the winner's owner/we/be/addr/wdata (IF: we=0, be=4'hF), go to REQ. With no request, stay in IDLE.
  - REQ: mem_req_o=1, driven from the registers only, stable until accepted. If mem_gnt_i, go to RESP; otherwise stay in REQ.
  - RESP: mem_req_o=0, wait for mem_rvalid_i. On mem_rvalid_i, go to IDLE.
- Arbitration, evaluated in IDLE only:
  - Only D requesting: D wins. Only IF requesting: IF wins.
  - Both requesting: D wins unless the starve counter equals STARVE_MAX, in which case IF wins.
  - Starve counter increments when D wins while if_req_i is high. It clears when IF wins. It saturates at STARVE_MAX.
- Response path (combinational in RESP):
  - owner_rvalid_o = mem_rvalid_i, except IF when the kill flag is set or if_kill_i is high this cycle.
  - if_rdata_o = d_rdata_o = mem_rdata_i, unqualified. The non-owner's rvalid is 0.
- Kill:
  - if_kill_i while owner=IF in REQ or RESP sets the kill flag.
  - A REQ transaction still completes on the bus; it is not withdrawn.
  - Flag clears on entry to IDLE.
  - if_kill_i in IDLE, or with owner=D, has no effect.
  - After a kill, IF may present a new address immediately. That request is arbitrated at the next IDLE.
- Stalls:
  - if_stall_o = if_req_i & ~if_rvalid_o.
  - d_stall_o = d_req_i & ~d_rvalid_o.
- Latency:
  - Request seen in IDLE at cycle N; mem_req_o at N+1.
  - With gnt at N+1 and rvalid at N+2, the requester's rvalid is at N+2.
  - The earliest next arbitration is N+3 (back-to-back occupancy is 3 cycles).
- Illegal conditions:
  - mem_rvalid_i outside RESP is ignored.
  - mem_rvalid_i in the same cycle as mem_gnt_i is illegal for the memory.

Test Plan:
- IF-only read, addr 0x100, gnt same cycle, rvalid 1 cycle later, rdata 0x00500093 -> mem_req_o at N+1 with addr 0x100, we=0, be=F; if_rvalid_o=1 and if_rdata_o=0x00500093 at N+2; if_stall_o falls at N+2.
- D write, addr 0x2000, be=4'b0011, wdata 0xDEADBEEF, gnt delayed 3 cycles -> mem_req_o and all bus fields held for 3 cycles unchanged; d_rvalid_o pulses once after rvalid; d_stall_o high until then.
- IF and D both request continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; counter observed 0..4 then 0.
- IF owns, in RESP; if_kill_i pulsed one cycle; rvalid arrives 2 cycles later -> if_rvalid_o stays 0; next IDLE arbitrates the new if_addr_i 0x200; the following response is delivered.
- if_kill_i coincident with mem_rvalid_i for an IF transaction -> if_rvalid_o=0. if_kill_i with owner=D -> d_rvalid_o unaffected.
- rst_ni asserted low while in REQ with mem_req_o=1 -> mem_req_o and all outputs 0 immediately (asynchronously); after release, state is IDLE and a pending d_req_i issues on the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory bus between the instruction-fetch
//   requester (IF) and the data load/store requester (D). One transaction
//   is outstanding at a time. D has priority, and IF is forced to win after
//   STARVE_MAX consecutive losses. Responses to fetches killed by a
//   redirect are swallowed.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   if_req_i/if_addr_i     IF read request and word address
//   if_kill_i              fetch redirect, drops the in-flight IF response
//   if_rvalid_o/if_rdata_o IF response (one-cycle pulse) and data
//   if_stall_o             IF stage must hold
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i  D request fields
//   d_rvalid_o/d_rdata_o   D response (also pulses for writes) and data
//   d_stall_o              MEM stage must hold
//   mem_req_o..mem_wdata_o registered memory request fields
//   mem_gnt_i              memory accepted the request this cycle
//   mem_rvalid_i/mem_rdata_i  memory response and read data
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic       OWN_D      = 1'b0;
  localparam logic       OWN_IF     = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      r_state;
  logic        r_owner;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_starve;
  logic        r_kill;

  logic        w_if_wins;
  logic        w_if_rvalid;
  logic        w_d_rvalid;

  // Arbitration: IF wins when alone, or when D is also asking but IF has starved
  always_comb begin
    w_if_wins = 1'b0;
    if (if_req_i && (!d_req_i || (r_starve == STARVE_LIM))) begin
      w_if_wins = 1'b1;
    end else begin
      w_if_wins = 1'b0;
    end
  end

  // Response steering: only the owner sees rvalid; a killed fetch sees nothing
  always_comb begin
    w_if_rvalid = 1'b0;
    w_d_rvalid  = 1'b0;
    if ((r_state == ST_RESP) && mem_rvalid_i) begin
      if (r_owner == OWN_IF) begin
        // The same-cycle kill term covers a redirect that coincides with the response
        w_if_rvalid = !r_kill && !if_kill_i;
      end else begin
        w_d_rvalid = 1'b1;
      end
    end else begin
      w_if_rvalid = 1'b0;
      w_d_rvalid  = 1'b0;
    end
  end

  assign if_rvalid_o = w_if_rvalid;
  assign d_rvalid_o  = w_d_rvalid;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

  // Stalls are held low during reset so every output reads 0 while rst_ni is low
  assign if_stall_o  = rst_ni & if_req_i & ~w_if_rvalid;
  assign d_stall_o   = rst_ni & d_req_i & ~w_d_rvalid;

  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  // Transaction FSM, request registers, starvation counter and kill flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_D;
      r_we     <= 1'b0;
      r_be     <= 4'h0;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_starve <= 4'd0;
      r_kill   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_kill <= 1'b0;
          if (if_req_i || d_req_i) begin
            r_state <= ST_REQ;
            if (w_if_wins) begin
              r_owner  <= OWN_IF;
              r_we     <= 1'b0;
              r_be     <= 4'hF;
              r_addr   <= if_addr_i;
              r_wdata  <= 32'h0000_0000;
              r_starve <= 4'd0;
            end else begin
              r_owner <= OWN_D;
              r_we    <= d_we_i;
              r_be    <= d_be_i;
              r_addr  <= d_addr_i;
              r_wdata <= d_wdata_i;
              // Count a loss only while IF is actually waiting
              if (if_req_i && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + 4'd1;
              end
            end
          end
        end
        ST_REQ: begin
          // A killed fetch still finishes on the bus; only its response is dropped
          if (if_kill_i && (r_owner == OWN_IF)) begin
            r_kill <= 1'b1;
          end
          if (mem_gnt_i) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_rvalid_i) begin
            r_state <= ST_IDLE;
            r_kill  <= 1'b0;
          end else if (if_kill_i && (r_owner == OWN_IF)) begin
            r_kill <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory with
// programmable grant/response delays, a response scoreboard per requester,
// and directed scenarios for priority, starvation, kill and reset.
module tb_mem_port_arbiter;

  logic        clk_i, rst_ni;
  logic        if_req_i, if_kill_i;
  logic [31:0] if_addr_i;
  logic        if_rvalid_o, if_stall_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_rvalid_o, d_stall_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] log_addr[$];
  int          log_starve[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  bit          if_done = 1'b0;
  bit          d_done  = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_wait  = 0;
  int          m_rv    = 0;
  logic [31:0] m_rd;
  logic [31:0] m_w;
  int          d_n, if_n;
  bit          exp_is_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int          exp_cnt   [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Preloaded memory contents: one fixed instruction word, a pattern elsewhere
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic out_zero(input string t);
    chk({t, "_mem_req"},   32'(mem_req_o),   32'd0);
    chk({t, "_mem_we"},    32'(mem_we_o),    32'd0);
    chk({t, "_mem_be"},    32'(mem_be_o),    32'd0);
    chk({t, "_mem_addr"},  mem_addr_o,       32'd0);
    chk({t, "_mem_wdata"}, mem_wdata_o,      32'd0);
    chk({t, "_if_rvalid"}, 32'(if_rvalid_o), 32'd0);
    chk({t, "_d_rvalid"},  32'(d_rvalid_o),  32'd0);
    chk({t, "_if_stall"},  32'(if_stall_o),  32'd0);
    chk({t, "_d_stall"},   32'(d_stall_o),   32'd0);
  endtask

  task automatic wait_if(input int budget);
    for (int c = 0; c < budget && !if_done; c++) begin
      @(negedge clk_i); #2;
    end
    chk("if_resp_timeout", 32'(if_done), 32'd1);
  endtask

  task automatic wait_d(input int budget);
    for (int c = 0; c < budget && !d_done; c++) begin
      @(negedge clk_i); #2;
    end
    chk("d_resp_timeout", 32'(d_done), 32'd1);
  endtask

  // Behavioural memory: grant after gnt_delay waiting cycles, respond rv_delay cycles later
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
      if (!rst_ni) begin
        m_busy = 1'b0; m_wait = 0;
      end else if (m_busy) begin
        if (m_rv == rv_delay) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = m_rd; m_busy = 1'b0;
        end else m_rv++;
      end else if (mem_req_o) begin
        if (m_wait == gnt_delay) begin
          mem_gnt_i = 1'b1; m_wait = 0; m_busy = 1'b1; m_rv = 0;
          log_addr.push_back(mem_addr_o);
          log_starve.push_back(int'(dut.r_starve));
          if (mem_we_o) begin
            m_w = mem_read(mem_addr_o);
            for (int b = 0; b < 4; b++)
              if (mem_be_o[b]) m_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
            mem_arr[mem_addr_o] = m_w;
            m_rd = 32'd0;
          end else m_rd = mem_read(mem_addr_o);
        end else m_wait++;
      end
    end
  end

  // Scoreboard: every response pops the expectation pushed when its request was driven
  initial begin
    forever begin
      @(negedge clk_i); #1;
      if (if_rvalid_o) begin
        if_done = 1'b1;
        if (if_exp_q.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata_o, if_exp_q.pop_front());
      end
      if (d_rvalid_o) begin
        d_done = 1'b1;
        if (d_exp_q.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
        else chk("d_rdata", d_rdata_o, d_exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b1; if_req_i = 1'b0; if_kill_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    #2 rst_ni = 1'b0;
    #1 out_zero("rst");
    repeat (2) @(negedge clk_i);
    #3 rst_ni = 1'b1;
    @(negedge clk_i); #2 out_zero("idle");

    // IF-only read, immediate grant, response one cycle later
    @(negedge clk_i);
    if_done = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h100; if_exp_q.push_back(32'h0050_0093);
    #2 chk("t1_stall_n", 32'(if_stall_o), 32'd1);
    @(negedge clk_i); #2;
    chk("t1_mem_req", 32'(mem_req_o), 32'd1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_we", 32'(mem_we_o), 32'd0);
    chk("t1_be", 32'(mem_be_o), 32'hF);
    chk("t1_stall_n1", 32'(if_stall_o), 32'd1);
    @(negedge clk_i); #2;
    chk("t1_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("t1_rdata", if_rdata_o, 32'h0050_0093);
    chk("t1_stall_n2", 32'(if_stall_o), 32'd0);
    @(negedge clk_i); if_req_i = 1'b0;

    // D write with grant delayed three cycles
    gnt_delay = 3;
    @(negedge clk_i);
    d_done = 1'b0; d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
    d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF; d_exp_q.push_back(32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); #2;
      chk($sformatf("t2_req_c%0d", k), 32'(mem_req_o), 32'd1);
      chk($sformatf("t2_addr_c%0d", k), mem_addr_o, 32'h2000);
      chk($sformatf("t2_we_c%0d", k), 32'(mem_we_o), 32'd1);
      chk($sformatf("t2_be_c%0d", k), 32'(mem_be_o), 32'h3);
      chk($sformatf("t2_wdata_c%0d", k), mem_wdata_o, 32'hDEAD_BEEF);
      chk($sformatf("t2_stall_c%0d", k), 32'(d_stall_o), 32'd1);
      chk($sformatf("t2_rvalid_c%0d", k), 32'(d_rvalid_o), 32'd0);
    end
    @(negedge clk_i); #2;
    gnt_delay = 0;
    chk("t2_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("t2_stall_end", 32'(d_stall_o), 32'd0);
    @(negedge clk_i); d_req_i = 1'b0; d_we_i = 1'b0;
    #2 chk("t2_rvalid_once", 32'(d_rvalid_o), 32'd0);
    // Read back: low two bytes replaced by the write
    @(negedge clk_i);
    d_done = 1'b0; d_req_i = 1'b1; d_be_i = 4'hF; d_addr_i = 32'h2000;
    d_exp_q.push_back(32'h9EEF_BEEF);
    wait_d(40);
    @(negedge clk_i); d_req_i = 1'b0;

    // Both requesters continuously: 8 D reads and 2 IF reads
    log_addr.delete(); log_starve.delete(); if_done = 1'b0; d_done = 1'b0;
    @(negedge clk_i);
    d_req_i = 1'b1; d_addr_i = 32'h3000; d_exp_q.push_back(init_word(32'h3000));
    if_req_i = 1'b1; if_addr_i = 32'h1000; if_exp_q.push_back(init_word(32'h1000));
    d_n = 1; if_n = 1;
    for (int c = 0; c < 300 && (if_req_i || d_req_i); c++) begin
      @(negedge clk_i);
      if (d_done) begin
        d_done = 1'b0;
        if (d_n < 8) begin
          d_n++; d_addr_i = d_addr_i + 32'd4; d_exp_q.push_back(init_word(d_addr_i));
        end else d_req_i = 1'b0;
      end
      if (if_done) begin
        if_done = 1'b0;
        if (if_n < 2) begin
          if_n++; if_addr_i = if_addr_i + 32'd4; if_exp_q.push_back(init_word(if_addr_i));
        end else if_req_i = 1'b0;
      end
    end
    chk("t3_finished", 32'(if_req_i | d_req_i), 32'd0);
    chk("t3_grants", log_addr.size(), 32'd10);
    for (int k = 0; k < 10 && k < log_addr.size(); k++) begin
      chk($sformatf("t3_grant%0d_is_if", k), 32'(log_addr[k][15:12] == 4'h1), 32'(exp_is_if[k]));
      chk($sformatf("t3_starve%0d", k), log_starve[k], exp_cnt[k]);
    end

    // Kill while IF owns the bus in RESP; response arrives two cycles later
    rv_delay = 2;
    @(negedge clk_i);
    if_done = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h180;
    @(negedge clk_i); #2 chk("t4_addr_old", mem_addr_o, 32'h180);
    @(negedge clk_i);
    if_kill_i = 1'b1; if_addr_i = 32'h200; if_exp_q.push_back(init_word(32'h200));
    #2 chk("t4_rvalid_c2", 32'(if_rvalid_o), 32'd0);
    @(negedge clk_i); if_kill_i = 1'b0;
    @(negedge clk_i); #2;
    chk("t4_mem_rvalid_seen", 32'(mem_rvalid_i), 32'd1);
    chk("t4_suppressed", 32'(if_rvalid_o), 32'd0);
    chk("t4_stall_held", 32'(if_stall_o), 32'd1);
    @(negedge clk_i); rv_delay = 0;
    @(negedge clk_i); #2;
    chk("t4_new_req", 32'(mem_req_o), 32'd1);
    chk("t4_new_addr", mem_addr_o, 32'h200);
    wait_if(20);
    @(negedge clk_i); if_req_i = 1'b0;

    // Kill coincident with the IF response
    @(negedge clk_i); if_req_i = 1'b1; if_addr_i = 32'h280;
    @(negedge clk_i); #2 chk("t5_addr", mem_addr_o, 32'h280);
    @(negedge clk_i); if_kill_i = 1'b1;
    #2 chk("t5_mem_rvalid_seen", 32'(mem_rvalid_i), 32'd1);
    chk("t5_suppressed", 32'(if_rvalid_o), 32'd0);
    @(negedge clk_i); if_kill_i = 1'b0; if_req_i = 1'b0;

    // Kill during a D transaction does not touch the D response
    @(negedge clk_i);
    d_done = 1'b0; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h3100;
    d_exp_q.push_back(init_word(32'h3100));
    @(negedge clk_i);
    @(negedge clk_i); if_kill_i = 1'b1;
    #2 chk("t5_d_rvalid", 32'(d_rvalid_o), 32'd1);
    @(negedge clk_i); if_kill_i = 1'b0; d_req_i = 1'b0;

    // Asynchronous reset while a D request waits for grant
    gnt_delay = 10;
    @(negedge clk_i);
    d_done = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h3200; d_exp_q.push_back(init_word(32'h3200));
    @(negedge clk_i); #2 chk("t6_req_before", 32'(mem_req_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1 out_zero("t6_async");
    gnt_delay = 0;
    @(negedge clk_i); #3 rst_ni = 1'b1;
    #1 chk("t6_idle_after_release", 32'(mem_req_o), 32'd0);
    @(negedge clk_i); #2;
    chk("t6_reissue_req", 32'(mem_req_o), 32'd1);
    chk("t6_reissue_addr", mem_addr_o, 32'h3200);
    wait_d(20);
    @(negedge clk_i); d_req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    chk("if_queue_empty", if_exp_q.size(), 32'd0);
    chk("d_queue_empty", d_exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
